act_interp_pipe: RTL and testbench



---
 rtl/act_interp_pipe_pkg.sv | 33 +++
 rtl/act_interp_pipe.sv | 103 ++++++++++
 tb/tb_act_interp_pipe.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/act_interp_pipe_pkg.sv
// ---------------------------------------------------------------------------
// act_interp_pipe_pkg
// Shared definitions for the piecewise-linear activation interpolator:
//   - default widths (data, LUT address, fraction)
//   - signed activation data type
//   - sat(): clamp a wide signed value into a w-bit signed range, shared
//     with other layers that need the same output guard
// ---------------------------------------------------------------------------
package act_interp_pipe_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_FRAC_W = DEF_DATA_W - DEF_ADDR_W;

   typedef logic signed [DEF_DATA_W-1:0] data_t;

   // Clamp v to [-2^(w-1), 2^(w-1)-1]; result is returned at 32 bits and the
   // caller keeps the low w bits.
   function automatic logic signed [31:0] sat(input logic signed [31:0] v,
                                              input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/act_interp_pipe.sv
// ---------------------------------------------------------------------------
// act_interp_pipe
// Three-stage piecewise-linear activation interpolator sitting between a
// neuron's pre-activation sum and an external combinational activation LUT.
//   stage 1 : register LUT address (x MSBs) and fraction (x LSBs)
//   stage 2 : capture LUT base and (next - base) * frac
//   stage 3 : y = sat(base + floor(prod / 2^FRAC_W))
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready/in_x upstream handshake and signed input
//   lut_address            LUT address, straight from the stage-1 register
//   lut_base/lut_next      combinational LUT return (entry, following entry)
//   out_valid/out_ready    downstream handshake
//   out_y                  signed interpolated activation
// The whole pipe stalls as one unit when the output is full and not taken.
// ---------------------------------------------------------------------------
module act_interp_pipe
   import act_interp_pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int FRAC_W = DATA_W - ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_x,
   output logic        [ADDR_W-1:0] lut_address,
   input  logic signed [DATA_W-1:0] lut_base,
   input  logic signed [DATA_W-1:0] lut_next,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_y
);

   localparam int DW = DATA_W + 1;           // base/next difference
   localparam int PW = DATA_W + FRAC_W + 1;  // difference * fraction
   localparam int SW = DATA_W + 2;           // final sum before clamp

   logic                     en;
   logic                     v1, v2, v3;
   logic        [ADDR_W-1:0] addr1;
   logic        [FRAC_W-1:0] frac1;
   logic signed [DATA_W-1:0] base2;
   logic signed [PW-1:0]     prod2;
   logic signed [DATA_W-1:0] y3;

   logic signed [DW-1:0]     diff_c;
   logic signed [FRAC_W:0]   frac_ext_c;
   logic signed [PW-1:0]     prod_c;
   logic signed [PW-1:0]     prod_sh_c;
   logic signed [SW-1:0]     sum_c;
   logic signed [31:0]       sat_c;
   logic signed [DATA_W-1:0] y_c;

   assign en          = !(v3 && !out_ready);
   assign in_ready    = en;
   assign out_valid   = v3;
   assign out_y       = y3;
   assign lut_address = addr1;

   always_comb begin
      diff_c     = DW'(lut_next) - DW'(lut_base);
      // Fraction is an unsigned weight; the extra zero MSB keeps it positive
      // in the signed multiply.
      frac_ext_c = {1'b0, frac1};
      prod_c     = PW'(diff_c) * PW'(frac_ext_c);
      // Arithmetic shift gives floor, so negative slopes round toward -inf.
      prod_sh_c  = prod2 >>> FRAC_W;
      sum_c      = SW'(base2) + SW'(prod_sh_c);
      sat_c      = sat(32'(sum_c), DATA_W);
      y_c        = sat_c[DATA_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         v3    <= 1'b0;
         addr1 <= '0;
         frac1 <= '0;
         base2 <= '0;
         prod2 <= '0;
         y3    <= '0;
      end else if (en) begin
         v1 <= in_valid;
         if (in_valid) begin
            addr1 <= in_x[DATA_W-1 -: ADDR_W];
            frac1 <= in_x[FRAC_W-1:0];
         end
         v2    <= v1;
         base2 <= lut_base;
         prod2 <= prod_c;
         v3    <= v2;
         // Output register only moves for real items so bubbles leave the
         // last result visible.
         if (v2)
            y3 <= y_c;
      end
   end

endmodule

// File: tb/tb_act_interp_pipe.sv
module tb_act_interp_pipe;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] in_x;
   logic        [3:0] lut_address;
   logic signed [7:0] lut_base;
   logic signed [7:0] lut_next;
   logic              out_valid;
   logic              out_ready;
   logic signed [7:0] out_y;

   int checks;
   int failures;

   logic              ovr;
   logic signed [7:0] ovr_base;
   logic signed [7:0] ovr_next;

   int got_q[$];
   int exp_q[$];

   act_interp_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .lut_address(lut_address),
      .lut_base   (lut_base),
      .lut_next   (lut_next),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // identity-ramp LUT: entry a = a*16 (signed), next(7)=entry 7, next(15)=entry 0
   function automatic int ramp(input int a);
      return (a < 8) ? a * 16 : a * 16 - 256;
   endfunction

   function automatic int nxt(input int a);
      if (a == 7)  return ramp(7);
      if (a == 15) return ramp(0);
      return ramp(a + 1);
   endfunction

   function automatic int model(input logic [7:0] x);
      int a, f, b, n;
      a = int'(x[7:4]);
      f = int'(x[3:0]);
      b = ramp(a);
      n = nxt(a);
      return b + (((n - b) * f) >>> 4);
   endfunction

   assign lut_base = ovr ? ovr_base : 8'(ramp(int'(lut_address)));
   assign lut_next = ovr ? ovr_next : 8'(nxt(int'(lut_address)));

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) got_q.push_back(int'(out_y));
         if (in_valid && in_ready)   exp_q.push_back(model(in_x));
      end
   end

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      checks++; if (out_y !== 8'sd0) begin failures++; $display("FAIL reset_out_y got=%0d want=0", out_y); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
      checks++; if (lut_address !== 4'd0) begin failures++; $display("FAIL reset_lut_address got=%0d want=0", lut_address); end
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL idle got valid=%0b ready=%0b want valid=0 ready=1", out_valid, in_ready); end
   endtask

   task automatic test_single(input logic [7:0] x, input int exp, input string nm);
      @(posedge clk); #1;
      in_valid = 1'b1; in_x = x; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_early1 out_valid got=%0b want=0", nm, out_valid); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_early2 out_valid got=%0b want=0", nm, out_valid); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL %s_latency out_valid got=%0b want=1", nm, out_valid); end
      checks++; if (out_y !== 8'(exp)) begin failures++; $display("FAIL %s_value out_y got=%0d want=%0d", nm, out_y, exp); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_points();
      test_single(8'h25, 37,   "x25");
      test_single(8'h7F, 112,  "x7F_top");
      test_single(8'h80, -128, "x80");
      test_single(8'hF8, -8,   "xF8_wrap");
      ovr = 1'b1; ovr_base = 8'sd0; ovr_next = 8'sd5;
      test_single(8'h01, 0,  "floor_pos");
      ovr_next = -8'sd5;
      test_single(8'h01, -1, "floor_neg");
      ovr = 1'b0;
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int c = 0; c <= 18; c++) begin
         in_valid = (c < 16);
         in_x     = 8'(c);
         @(posedge clk); #1;
         if (c >= 2 && c <= 17) begin
            checks++;
            if (out_valid !== 1'b1 || out_y !== 8'(c - 2)) begin
               failures++;
               $display("FAIL stream_item%0d got valid=%0b y=%0d want valid=1 y=%0d", c - 2, out_valid, out_y, c - 2);
            end
         end
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_end out_valid got=%0b want=0", out_valid); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_backpressure();
      int i;
      logic acc;
      logic signed [7:0] held;
      i = 0; held = '0;
      got_q.delete(); exp_q.delete();
      @(posedge clk); #1;
      for (int c = 0; c < 24; c++) begin
         in_valid  = (i < 8);
         in_x      = 8'(8'h30 + i);
         out_ready = !(c >= 5 && c <= 8);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (c >= 5 && c <= 8) begin
            if (c == 5) held = out_y;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready c=%0d got=%0b want=0", c, in_ready); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid c=%0d got=%0b want=1", c, out_valid); end
            if (c > 5) begin
               checks++; if (out_y !== held) begin failures++; $display("FAIL bp_hold c=%0d got=%0d want=%0d", c, out_y, held); end
            end
         end
         @(posedge clk); #1;
         if (acc) i++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got_q.size() != 8) begin failures++; $display("FAIL bp_count got=%0d want=8", got_q.size()); end
      for (int k = 0; k < 8 && k < got_q.size(); k++) begin
         checks++;
         if (got_q[k] != 48 + k) begin failures++; $display("FAIL bp_item%0d got=%0d want=%0d", k, got_q[k], 48 + k); end
      end
   endtask

   task automatic test_random();
      int i, cyc;
      logic acc;
      logic [7:0] xr;
      i = 0; cyc = 0; xr = 8'($urandom);
      got_q.delete(); exp_q.delete();
      @(posedge clk); #1;
      while (i < 1000 && cyc < 20000) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_x      = xr;
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin i++; xr = 8'($urandom); end
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checks++; if (i != 1000) begin failures++; $display("FAIL rand_budget accepted=%0d want=1000", i); end
      checks++; if (got_q.size() != exp_q.size() || got_q.size() != 1000) begin failures++; $display("FAIL rand_count got=%0d exp=%0d want=1000", got_q.size(), exp_q.size()); end
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (got_q[k] != exp_q[k]) begin failures++; $display("FAIL rand_item%0d got=%0d want=%0d", k, got_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_reset_midstream();
      int seen;
      seen = 0;
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; in_x = 8'h11;
      @(posedge clk); #1; in_x = 8'h22;
      @(posedge clk); #1; in_x = 8'h33;
      @(posedge clk); #1; in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_y !== 8'sd0 || lut_address !== 4'd0) begin failures++; $display("FAIL midrst_clear got valid=%0b y=%0d addr=%0d want 0/0/0", out_valid, out_y, lut_address); end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL midrst_ghost outputs got=%0d want=0", seen); end
   endtask

   initial begin
      checks = 0; failures = 0;
      ovr = 1'b0; ovr_base = '0; ovr_next = '0;
      rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
      test_reset();
      test_points();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
